// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and default widths for the memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  // Encoding of the client that received the most recent grant
  localparam logic CLI_I = 1'b0;
  localparam logic CLI_D = 1'b1;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - two-way round-robin pick, one-hot or zero grant
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_gnt,
  output logic gnt_i,
  output logic gnt_d
);

  // A lone requester always wins; on a tie the client not served last wins
  always_comb begin
    gnt_i = req_i & (~req_d | (last_gnt == CLI_D));
    gnt_d = req_d & (~req_i | (last_gnt == CLI_I));
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one line memory port between the I-cache and D-cache
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)
(
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t state, state_nxt;
  logic   last_gnt, last_gnt_nxt;
  logic   req_i, req_d, gnt_i, gnt_d;

  assign req_i = i_mem_read | i_mem_write;
  assign req_d = d_mem_read | d_mem_write;

  rr_pick2 u_pick (
    .req_i    (req_i),
    .req_d    (req_d),
    .last_gnt (last_gnt),
    .gnt_i    (gnt_i),
    .gnt_d    (gnt_d)
  );

  // State and round-robin history; last_gnt resets to D so I wins the first tie
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state    <= IDLE;
      last_gnt <= CLI_D;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Grant only from IDLE; a granted transaction runs until mem_ready regardless of the client
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (gnt_i) begin
          state_nxt    = GNT_I;
          last_gnt_nxt = CLI_I;
        end else if (gnt_d) begin
          state_nxt    = GNT_D;
          last_gnt_nxt = CLI_D;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request registers: load on grant, hold while granted, clear on completion
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE) begin
      if (gnt_i) begin
        mem_read  <= i_mem_read;
        mem_write <= i_mem_write;
        mem_addr  <= i_mem_addr;
        mem_wdata <= i_mem_wdata;
      end else if (gnt_d) begin
        mem_read  <= d_mem_read;
        mem_write <= d_mem_write;
        mem_addr  <= d_mem_addr;
        mem_wdata <= d_mem_wdata;
      end
    end else if (mem_ready) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end
  end

  // Completion goes only to the owner of the current grant; read data is a passthrough
  assign i_mem_ready = (state == GNT_I) & mem_ready;
  assign d_mem_ready = (state == GNT_D) & mem_ready;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         proc_reset = 1'b1;
  logic         i_mem_read = 1'b0, i_mem_write = 1'b0;
  logic [27:0]  i_mem_addr = '0;
  logic [127:0] i_mem_wdata = '0;
  logic [127:0] i_mem_rdata;
  logic         i_mem_ready;
  logic         d_mem_read = 1'b0, d_mem_write = 1'b0;
  logic [27:0]  d_mem_addr = '0;
  logic [127:0] d_mem_wdata = '0;
  logic [127:0] d_mem_rdata;
  logic         d_mem_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  typedef struct {
    bit           is_d;
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   waited;

  mem_arbiter dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input logic rd, input logic wr,
                      input logic [27:0] addr, input logic [127:0] wdata);
    exp_t e;
    e.is_d = is_d; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    proc_reset = 1'b1;
    repeat (2) step();
    proc_reset = 1'b0;
  endtask

  // Wait for the next memory request, match it against the scoreboard, then complete it
  task automatic serve(input int lat, input bit drop_d);
    exp_t e;
    logic [127:0] rd_line;
    waited = 0;
    while (!(mem_read | mem_write) && waited < 10) begin
      step();
      waited++;
    end
    check("grant_latency", 128'(waited), 128'(1));
    if (waited >= 10) return;
    check("sb_nonempty", 128'(q.size() != 0), 128'(1));
    if (q.size() == 0) return;
    e = q.pop_front();
    check("mem_read", 128'(mem_read), 128'(e.rd));
    check("mem_write", 128'(mem_write), 128'(e.wr));
    check("mem_addr", 128'(mem_addr), 128'(e.addr));
    check("mem_wdata", mem_wdata, e.wdata);
    if (drop_d) d_mem_read = 1'b0;
    repeat (lat - 1) step();
    check("held_read", 128'(mem_read), 128'(e.rd));
    check("held_addr", 128'(mem_addr), 128'(e.addr));
    rd_line = {$urandom, $urandom, $urandom, $urandom};
    if (!e.is_d && e.addr == 28'h10) rd_line = {16{8'hA5}};
    mem_rdata = rd_line;
    mem_ready = 1'b1;
    #1;
    check("i_ready", 128'(i_mem_ready), 128'(!e.is_d));
    check("d_ready", 128'(d_mem_ready), 128'(e.is_d));
    check("rdata_pass", e.is_d ? d_mem_rdata : i_mem_rdata, rd_line);
  endtask

  // Cycle after completion: request registers must be cleared
  task automatic finish_ready();
    step();
    mem_ready = 1'b0;
    #1;
    check("clr_read", 128'(mem_read), 128'(0));
    check("clr_write", 128'(mem_write), 128'(0));
    check("clr_addr", 128'(mem_addr), 128'(0));
    check("clr_wdata", mem_wdata, 128'(0));
  endtask

  initial begin
    // Reset state
    reset_dut();
    check("rst_read", 128'(mem_read), 128'(0));
    check("rst_write", 128'(mem_write), 128'(0));
    check("rst_addr", 128'(mem_addr), 128'(0));
    check("rst_i_ready", 128'(i_mem_ready), 128'(0));
    check("rst_d_ready", 128'(d_mem_ready), 128'(0));

    // Single I read
    i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
    push(0, 1, 0, 28'h10, 128'h0);
    serve(3, 0);
    i_mem_read = 1'b0;
    finish_ready();

    // Simultaneous I read and D write, first tie after reset
    reset_dut();
    i_mem_read = 1'b1; i_mem_addr = 28'h10;
    d_mem_write = 1'b1; d_mem_addr = 28'h20; d_mem_wdata = 128'h1234;
    push(0, 1, 0, 28'h10, 128'h0);
    push(1, 0, 1, 28'h20, 128'h1234);
    serve(2, 0);
    i_mem_read = 1'b0;
    finish_ready();
    serve(2, 0);
    d_mem_write = 1'b0;
    finish_ready();

    // Both clients hold requests: strict alternation I, D, I, D, I, D
    reset_dut();
    i_mem_read = 1'b1; i_mem_addr = 28'h100;
    d_mem_read = 1'b1; d_mem_addr = 28'h200; d_mem_wdata = 128'h0;
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) push(0, 1, 0, 28'h100, 128'h0);
      else            push(1, 1, 0, 28'h200, 128'h0);
    end
    for (int n = 0; n < 6; n++) begin
      serve(1 + (n % 3), 0);
      if (n == 5) begin
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
      end
      finish_ready();
    end

    // D drops its read mid-transaction; access still completes
    d_mem_read = 1'b1; d_mem_addr = 28'h30;
    push(1, 1, 0, 28'h30, 128'h0);
    serve(3, 1);
    finish_ready();
    check("drop_ready_once", 128'(d_mem_ready), 128'(0));
    step();
    check("drop_idle", 128'(mem_read), 128'(0));

    // Asynchronous reset two cycles into a D read
    d_mem_read = 1'b1; d_mem_addr = 28'h40;
    step();
    check("d_grant", 128'(mem_read), 128'(1));
    check("d_grant_addr", 128'(mem_addr), 128'(28'h40));
    step();
    #2;
    proc_reset = 1'b1;
    #1;
    check("async_read", 128'(mem_read), 128'(0));
    check("async_addr", 128'(mem_addr), 128'(0));
    check("async_d_ready", 128'(d_mem_ready), 128'(0));
    d_mem_read = 1'b0;
    step();
    proc_reset = 1'b0;
    step();
    mem_ready = 1'b1;
    #1;
    check("late_i_ready", 128'(i_mem_ready), 128'(0));
    check("late_d_ready", 128'(d_mem_ready), 128'(0));
    step();
    mem_ready = 1'b0;
    step();
    check("late_idle_read", 128'(mem_read), 128'(0));
    check("late_idle_write", 128'(mem_write), 128'(0));
    check("sb_empty", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
